// File: rtl/csa_accum_pkg.sv
// Shared types and helpers for the carry-save multi-operand accumulator.
package csa_accum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        OUTPUT
    } state_t;

    // The accumulator grows by log2 of the operand count to hold a full stream.
    function automatic int acc_w(input int width, input int max_ops);
        return width + $clog2(max_ops);
    endfunction

endpackage

// File: rtl/csa_accum_ctrl_row.sv
// One row of 4:2 compressors with a lateral cout->cin ripple; the row adds
// x1+x2+x3+x4 into sum + 2*carry + 2^W*cout_msb without carry propagation.
module compressor_4_2_cell (
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    input  logic cin,
    output logic sum,
    output logic carry,
    output logic cout
);
    logic s1;

    always_comb begin
        s1    = x1 ^ x2 ^ x3;
        cout  = (x1 & x2) | (x1 & x3) | (x2 & x3);
        sum   = s1 ^ x4 ^ cin;
        carry = (s1 & x4) | (s1 & cin) | (x4 & cin);
    end
endmodule

module compressor_4_2_row #(
    parameter int W = 8
) (
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
    input  logic [W-1:0] x4,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry,
    output logic         cout_msb
);
    logic [W:0] cin_chain;

    assign cin_chain[0] = 1'b0;
    assign cout_msb     = cin_chain[W];

    for (genvar i = 0; i < W; i++) begin : g_cell
        compressor_4_2_cell u_cell (
            .x1   (x1[i]),
            .x2   (x2[i]),
            .x3   (x3[i]),
            .x4   (x4[i]),
            .cin  (cin_chain[i]),
            .sum  (sum[i]),
            .carry(carry[i]),
            .cout (cin_chain[i+1])
        );
    end
endmodule

// File: rtl/csa_accum_ctrl.sv
// Sequenced multi-operand accumulator: each beat folds two operands into a
// redundant sum/carry pair, and one carry-propagate add resolves the result.
module csa_accum_ctrl
    import csa_accum_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int MAX_OPS = 8,
    localparam int ACC_W   = acc_w(WIDTH, MAX_OPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             op_last_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [ACC_W-1:0] res_o,
    output logic             res_ovf_o,
    output logic             busy_o
);
    localparam int HALF  = MAX_OPS / 2;
    localparam int CNT_W = $clog2(HALF + 2);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   s_q, s_d;
    logic [ACC_W-1:0]   c_q, c_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               res_ovf_q, res_ovf_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [ACC_W-1:0]   row_sum;
    logic [ACC_W-1:0]   row_carry;
    logic               row_cout_msb;
    logic               accept;
    logic               unused_row_bits;

    compressor_4_2_row #(.W(ACC_W)) u_row (
        .x1      (s_q),
        .x2      (c_q),
        .x3      ({{(ACC_W-WIDTH){1'b0}}, op_a_i}),
        .x4      ({{(ACC_W-WIDTH){1'b0}}, op_b_i}),
        .sum     (row_sum),
        .carry   (row_carry),
        .cout_msb(row_cout_msb)
    );

    // Bits shifted out above ACC_W are discarded: results are modulo 2^ACC_W.
    assign unused_row_bits = row_cout_msb ^ row_carry[ACC_W-1];

    assign op_ready_o  = !rst && (state_q == IDLE || state_q == ACCUM);
    assign accept      = op_valid_i && op_ready_o;
    assign res_valid_o = (state_q == OUTPUT);
    assign busy_o      = (state_q != IDLE);
    assign res_o       = res_q;
    assign res_ovf_o   = res_ovf_q;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        ovf_d     = ovf_q;
        count_d   = count_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    s_d = row_sum;
                    c_d = {row_carry[ACC_W-2:0], 1'b0};
                    if (count_q <= CNT_W'(HALF)) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (count_q >= CNT_W'(HALF)) begin
                        ovf_d = 1'b1;
                    end
                    state_d = op_last_i ? RESOLVE : ACCUM;
                end
            end
            RESOLVE: begin
                res_d     = s_q + c_q;
                res_ovf_d = ovf_q;
                state_d   = OUTPUT;
            end
            OUTPUT: begin
                if (res_ready_i) begin
                    s_d     = '0;
                    c_d     = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s_q       <= '0;
            c_q       <= '0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
            ovf_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            c_q       <= c_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Scoreboard bench: stimulus pushes reference sums, a monitor checks every presented result.
module tb_csa_accum_ctrl;
    localparam int ACC_W = 11;
    localparam int MOD   = 2048;

    logic             clk = 1'b0;
    logic             rst;
    logic             op_valid_i;
    logic             op_ready_o;
    logic [7:0]       op_a_i;
    logic [7:0]       op_b_i;
    logic             op_last_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [ACC_W-1:0] res_o;
    logic             res_ovf_o;
    logic             busy_o;

    typedef struct {
        int unsigned res;
        bit          ovf;
    } exp_t;

    exp_t        expQ[$];
    int          errors    = 0;
    int          checks    = 0;
    int          readyPct  = 100;
    int unsigned runSum    = 0;
    int          nOps      = 0;

    csa_accum_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid_i (op_valid_i),
        .op_ready_o (op_ready_o),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .op_last_i  (op_last_i),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .res_o      (res_o),
        .res_ovf_o  (res_ovf_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    // Consumer: random readiness, refreshed just after each rising edge.
    initial begin
        res_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            res_ready_i = ($urandom_range(0, 99) < readyPct);
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one beat and blocks until it is accepted; the reference sum is pushed on the last beat.
    task automatic applyStimulus(input int a, input int b, input bit last);
        int  waited;
        bit  accepted;
        runSum += a + b;
        nOps   += 2;
        if (last) begin
            expQ.push_back('{runSum % MOD, nOps > 8});
            runSum = 0;
            nOps   = 0;
        end
        op_a_i     = 8'(a);
        op_b_i     = 8'(b);
        op_last_i  = last;
        op_valid_i = 1'b1;
        waited     = 0;
        accepted   = 1'b0;
        while (!accepted && waited < 300) begin
            @(negedge clk);
            if (op_ready_o === 1'b1) accepted = 1'b1;
            @(posedge clk);
            waited++;
        end
        #1;
        op_valid_i = 1'b0;
        op_last_i  = 1'b0;
        if (!accepted) checkOutput("beat_accept_timeout", 0, 1);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy_o !== 1'b0 || expQ.size() != 0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) checkOutput("idle_timeout", 0, 1);
    endtask

    // Monitor: every cycle a result is presented it must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (res_valid_o === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    checkOutput("res_o", res_o, expQ[0].res);
                    checkOutput("res_ovf_o", res_ovf_o, expQ[0].ovf);
                    checkOutput("op_ready_in_output", op_ready_o, 0);
                    if (res_ready_i === 1'b1) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        op_valid_i = 1'b0;
        op_a_i     = '0;
        op_b_i     = '0;
        op_last_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_res_o", res_o, 0);
        checkOutput("reset_res_valid", res_valid_o, 0);
        checkOutput("reset_op_ready", op_ready_o, 0);
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_ovf", res_ovf_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("idle_op_ready", op_ready_o, 1);

        $display("[TB] single beat");
        applyStimulus(3, 5, 1'b1);
        checkOutput("resolve_valid", res_valid_o, 0);
        checkOutput("resolve_op_ready", op_ready_o, 0);
        checkOutput("resolve_busy", busy_o, 1);
        @(posedge clk);
        #1;
        checkOutput("latency_valid", res_valid_o, 1);
        waitIdle();

        $display("[TB] four full beats");
        for (int i = 0; i < 4; i++) applyStimulus(255, 255, i == 3);
        checkOutput("resolve_op_ready_4", op_ready_o, 0);
        waitIdle();

        $display("[TB] five full beats, overflow");
        for (int i = 0; i < 5; i++) applyStimulus(255, 255, i == 4);
        waitIdle();

        $display("[TB] result backpressure");
        readyPct = 0;
        for (int i = 0; i < 4; i++) applyStimulus(10 + i, 20, i == 3);
        fork
            begin
                repeat (12) @(posedge clk);
                readyPct = 100;
            end
        join_none
        applyStimulus(1, 2, 1'b1);
        waitIdle();

        $display("[TB] reset mid-stream");
        applyStimulus(50, 60, 1'b0);
        applyStimulus(70, 80, 1'b0);
        runSum = 0;
        nOps   = 0;
        rst    = 1'b1;
        #1;
        checkOutput("midrst_res_o", res_o, 0);
        checkOutput("midrst_valid", res_valid_o, 0);
        checkOutput("midrst_op_ready", op_ready_o, 0);
        checkOutput("midrst_busy", busy_o, 0);
        checkOutput("midrst_ovf", res_ovf_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(7, 9, 1'b1);
        waitIdle();

        $display("[TB] random streams");
        for (int s = 0; s < 1000; s++) begin
            int len;
            len      = $urandom_range(1, 4);
            readyPct = $urandom_range(30, 100);
            for (int j = 0; j < len; j++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                applyStimulus($urandom_range(0, 255), $urandom_range(0, 255), j == len - 1);
            end
        end
        readyPct = 100;
        waitIdle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
